// File: rtl/uart_bridge_pkg.sv
// Shared command/response codes and FSM state types for the UART-to-bus bridge.
package uart_bridge_pkg;

  localparam logic [7:0] CMD_WR  = 8'h57;
  localparam logic [7:0] CMD_RD  = 8'h52;
  localparam logic [7:0] RSP_ACK = 8'h4B;
  localparam logic [7:0] RSP_ERR = 8'h3F;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_REQ,
    ST_XFER,
    ST_TX
  } bridge_state_e;

  typedef enum logic [1:0] {
    SER_IDLE,
    SER_LOAD,
    SER_WAIT
  } ser_state_e;

  typedef struct packed {
    bridge_state_e main_st;
    ser_state_e    ser_st;
  } bridge_dbg_t;

  // Single-byte responses sit in the top byte so they leave the serializer first.
  function automatic logic [31:0] rsp_byte(input logic [7:0] b);
    return {b, 24'h00_0000};
  endfunction

endpackage

// File: rtl/uart_resp_serializer.sv
// Sends a 1- or 4-byte response MSB first over the UART sender handshake and
// pulses done after the sender has gone idle following the last byte.
module uart_resp_serializer
  import uart_bridge_pkg::*;
(
  input  logic        CLK,
  input  logic        Reset,
  input  logic        load,
  input  logic [31:0] load_data,
  input  logic [2:0]  load_cnt,
  input  logic        tx_status,
  output logic [7:0]  tx_data,
  output logic        tx_en,
  output logic        done,
  output ser_state_e  dbg_state
);

  ser_state_e  state_q, state_d;
  logic [31:0] shreg;
  logic [2:0]  cnt;
  logic        guard;

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) state_q <= SER_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    tx_en   = 1'b0;
    done    = 1'b0;
    case (state_q)
      SER_IDLE: if (load) state_d = SER_LOAD;
      SER_LOAD: begin
        if (tx_status) begin
          tx_en   = 1'b1;
          state_d = SER_WAIT;
        end
      end
      SER_WAIT: begin
        // tx_status may still read idle the cycle after tx_en; guard skips it.
        if (!guard && tx_status) begin
          if (cnt == 3'd1) begin
            done    = 1'b1;
            state_d = SER_IDLE;
          end else begin
            state_d = SER_LOAD;
          end
        end
      end
      default: state_d = SER_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      shreg <= 32'h0;
      cnt   <= 3'd0;
      guard <= 1'b0;
    end else begin
      guard <= tx_en;
      if (state_q == SER_IDLE && load) begin
        shreg <= load_data;
        cnt   <= load_cnt;
      end else if (state_q == SER_WAIT && !guard && tx_status) begin
        shreg <= {shreg[23:0], 8'h00};
        cnt   <= cnt - 3'd1;
      end
    end
  end

  assign tx_data   = shreg[31:24];
  assign dbg_state = state_q;

endmodule

// File: rtl/uart_bus_bridge.sv
// UART command bytes -> single read/write cycles on the peripheral bus, with reply bytes.
// Optional inter-byte frame timeout enabled by defining UART_BRIDGE_TIMEOUT_EN.
// Bus handshake: bus_req holds from REQ through XFER; rd/wr strobe exactly in the XFER cycle.
module uart_bus_bridge
  import uart_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 32'd2_000_000
)
(
  input  logic        CLK,
  input  logic        Reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_status,
  output logic [7:0]  tx_data,
  output logic        tx_en,
  input  logic        tx_status,
  output logic        bus_req,
  input  logic        bus_gnt,
  output logic        rd,
  output logic        wr,
  output logic [31:0] addr,
  output logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic        busy,
  output bridge_dbg_t dbg_state
);

  bridge_state_e state_q, state_d;
  logic [1:0]    byte_cnt;
  logic          is_wr;
  logic          load;
  logic [31:0]   load_data;
  logic [2:0]    load_cnt;
  logic          ser_done;
  logic          timeout;
  ser_state_e    ser_state;

`ifdef UART_BRIDGE_TIMEOUT_EN
  logic [31:0] to_cnt;

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset)                                                   to_cnt <= 32'd0;
    else if (rx_status || !(state_q == ST_ADDR || state_q == ST_DATA)) to_cnt <= 32'd0;
    else                                                         to_cnt <= to_cnt + 32'd1;
  end

  assign timeout = (state_q == ST_ADDR || state_q == ST_DATA) && !rx_status &&
                   (to_cnt >= TIMEOUT_CYCLES - 32'd1);
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    load      = 1'b0;
    load_data = rsp_byte(RSP_ERR);
    load_cnt  = 3'd1;
    case (state_q)
      ST_IDLE: begin
        if (rx_status) begin
          if (rx_data == CMD_WR || rx_data == CMD_RD) begin
            state_d = ST_ADDR;
          end else begin
            load    = 1'b1;
            state_d = ST_TX;
          end
        end
      end
      ST_ADDR: begin
        if (timeout) begin
          load    = 1'b1;
          state_d = ST_TX;
        end else if (rx_status && byte_cnt == 2'd3) begin
          state_d = is_wr ? ST_DATA : ST_REQ;
        end
      end
      ST_DATA: begin
        if (timeout) begin
          load    = 1'b1;
          state_d = ST_TX;
        end else if (rx_status && byte_cnt == 2'd3) begin
          state_d = ST_REQ;
        end
      end
      ST_REQ: if (bus_gnt) state_d = ST_XFER;
      ST_XFER: begin
        // Read data is only valid this cycle, so it goes straight into the serializer.
        load      = 1'b1;
        load_data = is_wr ? rsp_byte(RSP_ACK) : rdata;
        load_cnt  = is_wr ? 3'd1 : 3'd4;
        state_d   = ST_TX;
      end
      ST_TX: if (ser_done) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      addr     <= 32'h0;
      wdata    <= 32'h0;
      byte_cnt <= 2'd0;
      is_wr    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          byte_cnt <= 2'd0;
          if (rx_status) is_wr <= (rx_data == CMD_WR);
        end
        ST_ADDR: if (rx_status) begin
          addr     <= {addr[23:0], rx_data};
          byte_cnt <= byte_cnt + 2'd1;
        end
        ST_DATA: if (rx_status) begin
          wdata    <= {wdata[23:0], rx_data};
          byte_cnt <= byte_cnt + 2'd1;
        end
        default: ;
      endcase
    end
  end

  uart_resp_serializer u_ser (
    .CLK       (CLK),
    .Reset     (Reset),
    .load      (load),
    .load_data (load_data),
    .load_cnt  (load_cnt),
    .tx_status (tx_status),
    .tx_data   (tx_data),
    .tx_en     (tx_en),
    .done      (ser_done),
    .dbg_state (ser_state)
  );

  assign busy      = (state_q != ST_IDLE);
  assign bus_req   = (state_q == ST_REQ) || (state_q == ST_XFER);
  assign wr        = (state_q == ST_XFER) && is_wr;
  assign rd        = (state_q == ST_XFER) && !is_wr;
  assign dbg_state = '{main_st: state_q, ser_st: ser_state};

endmodule
